// File: rtl/lcd_bus_rx.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_bus_rx
//  Description : Receiver for an 8080-style 8-bit LCD controller bus, as seen
//                by a display panel. Decodes commands, tracks the CASET/PASET
//                drawing window, assembles RAMWR byte pairs into RGB565
//                pixels with auto-incrementing column/page addresses, keeps
//                the display status flags and generates the tearing-effect
//                (fmark) pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    P_LOW_FIRST  1: first RAMWR byte is pixel[7:0]; 0: first is pixel[15:8]
//    P_TE_PERIOD  tearing-effect frame period in i_clk cycles
//    P_TE_PULSE   fmark high time in i_clk cycles (< P_TE_PERIOD)
//  Ports
//    i_clk        system clock, rising edge
//    i_reset      synchronous active-high reset
//    i_lcd_data   bus data byte (synchronous to i_clk)
//    i_lcd_rs     0 = command, 1 = parameter / pixel data
//    i_lcd_wr     active-low write strobe, byte taken on its rising edge
//    o_lcd_fmark  tearing-effect pulse
//    o_pix_valid  one-cycle pixel strobe with o_pix_x / o_pix_y / o_pix_data
//    o_cmd_valid  one-cycle command strobe with o_cmd
//    o_disp_on    display-on flag
//    o_sleep_out  sleep-out flag
//    o_te_en      tearing-effect output enable flag
//    o_err        one-cycle protocol error pulse
// ============================================================================
module lcd_bus_rx #(
    parameter int P_LOW_FIRST = 1,
    parameter int P_TE_PERIOD = 1000,
    parameter int P_TE_PULSE  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_lcd_data,
    input  logic        i_lcd_rs,
    input  logic        i_lcd_wr,
    output logic        o_lcd_fmark,
    output logic        o_pix_valid,
    output logic [15:0] o_pix_x,
    output logic [15:0] o_pix_y,
    output logic [15:0] o_pix_data,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd,
    output logic        o_disp_on,
    output logic        o_sleep_out,
    output logic        o_te_en,
    output logic        o_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_TE_W = (P_TE_PERIOD > 1) ? $clog2(P_TE_PERIOD) : 1;
    localparam logic [c_TE_W-1:0] c_TE_LAST  = c_TE_W'(P_TE_PERIOD - 1);
    localparam logic [c_TE_W-1:0] c_TE_PULSE = c_TE_W'(P_TE_PULSE);

    localparam logic [15:0] c_EC_RST = 16'd239;
    localparam logic [15:0] c_EP_RST = 16'd319;

    localparam logic [7:0] c_CMD_NOP    = 8'h00;
    localparam logic [7:0] c_CMD_SWRST  = 8'h01;
    localparam logic [7:0] c_CMD_SLPIN  = 8'h10;
    localparam logic [7:0] c_CMD_SLPOUT = 8'h11;
    localparam logic [7:0] c_CMD_DISOFF = 8'h28;
    localparam logic [7:0] c_CMD_DISON  = 8'h29;
    localparam logic [7:0] c_CMD_CASET  = 8'h2A;
    localparam logic [7:0] c_CMD_PASET  = 8'h2B;
    localparam logic [7:0] c_CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] c_CMD_TEOFF  = 8'h34;
    localparam logic [7:0] c_CMD_TEON   = 8'h35;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CASET = 3'd1,
        PASET = 3'd2,
        RAMWR = 3'd3,
        OTHER = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    state_t            r_state, w_state_nx;
    logic              r_wr_q;
    logic              r_phase, w_phase_nx;
    logic [1:0]        r_pidx, w_pidx_nx;
    logic [7:0]        r_p0, w_p0_nx;
    logic [7:0]        r_p1, w_p1_nx;
    logic [7:0]        r_p2, w_p2_nx;
    logic [7:0]        r_byte0, w_byte0_nx;
    logic [15:0]       r_x, w_x_nx;
    logic [15:0]       r_y, w_y_nx;
    logic [15:0]       r_sc, w_sc_nx;
    logic [15:0]       r_ec, w_ec_nx;
    logic [15:0]       r_sp, w_sp_nx;
    logic [15:0]       r_ep, w_ep_nx;
    logic              r_disp_on, w_disp_on_nx;
    logic              r_sleep_out, w_sleep_out_nx;
    logic              r_te_en, w_te_en_nx;
    logic              r_pix_valid, w_pix_valid_nx;
    logic [15:0]       r_pix_x, w_pix_x_nx;
    logic [15:0]       r_pix_y, w_pix_y_nx;
    logic [15:0]       r_pix_data, w_pix_data_nx;
    logic              r_cmd_valid, w_cmd_valid_nx;
    logic [7:0]        r_cmd, w_cmd_nx;
    logic              r_err, w_err_nx;
    logic              w_soft_rst;
    logic [c_TE_W-1:0] r_te_cnt;
    logic              r_fmark;

    // ------------------------------------------------------------------------
    // Byte capture: the bus is already synchronous, so a rising edge of the
    // write strobe is simply "high now, low last cycle".
    // ------------------------------------------------------------------------
    logic w_capture;
    assign w_capture = i_lcd_wr & ~r_wr_q;

    // Window bounds formed by the fourth CASET/PASET byte; an inverted
    // window collapses to a single column/page at the start address.
    logic [15:0] w_win_start;
    logic [15:0] w_win_end_raw;
    logic [15:0] w_win_end;
    assign w_win_start   = {r_p0, r_p1};
    assign w_win_end_raw = {r_p2, i_lcd_data};
    assign w_win_end     = (w_win_start > w_win_end_raw) ? w_win_start : w_win_end_raw;

    // Second byte of a pixel completes the RGB565 word.
    logic [15:0] w_pix_word;
    assign w_pix_word = (P_LOW_FIRST != 0) ? {i_lcd_data, r_byte0} : {r_byte0, i_lcd_data};

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx     = r_state;
        w_phase_nx     = r_phase;
        w_pidx_nx      = r_pidx;
        w_p0_nx        = r_p0;
        w_p1_nx        = r_p1;
        w_p2_nx        = r_p2;
        w_byte0_nx     = r_byte0;
        w_x_nx         = r_x;
        w_y_nx         = r_y;
        w_sc_nx        = r_sc;
        w_ec_nx        = r_ec;
        w_sp_nx        = r_sp;
        w_ep_nx        = r_ep;
        w_disp_on_nx   = r_disp_on;
        w_sleep_out_nx = r_sleep_out;
        w_te_en_nx     = r_te_en;
        w_pix_valid_nx = 1'b0;
        w_pix_x_nx     = r_pix_x;
        w_pix_y_nx     = r_pix_y;
        w_pix_data_nx  = r_pix_data;
        w_cmd_valid_nx = 1'b0;
        w_cmd_nx       = r_cmd;
        w_err_nx       = 1'b0;
        w_soft_rst     = 1'b0;

        if (w_capture) begin
            if (!i_lcd_rs) begin
                // Command byte: always accepted, restarts parameter parsing.
                w_cmd_valid_nx = 1'b1;
                w_cmd_nx       = i_lcd_data;
                w_pidx_nx      = 2'd0;
                w_phase_nx     = 1'b0;
                // A half-received pixel is dropped and flagged.
                if (r_state == RAMWR && r_phase) begin
                    w_err_nx = 1'b1;
                end
                // Commands without their own state swallow any parameters.
                w_state_nx = OTHER;
                case (i_lcd_data)
                    c_CMD_NOP:    w_state_nx = IDLE;
                    c_CMD_CASET:  w_state_nx = CASET;
                    c_CMD_PASET:  w_state_nx = PASET;
                    c_CMD_RAMWR: begin
                        w_state_nx = RAMWR;
                        w_x_nx     = r_sc;
                        w_y_nx     = r_sp;
                    end
                    c_CMD_SLPOUT: w_sleep_out_nx = 1'b1;
                    c_CMD_SLPIN:  w_sleep_out_nx = 1'b0;
                    c_CMD_DISON:  w_disp_on_nx   = 1'b1;
                    c_CMD_DISOFF: w_disp_on_nx   = 1'b0;
                    c_CMD_TEON:   w_te_en_nx     = 1'b1;
                    c_CMD_TEOFF:  w_te_en_nx     = 1'b0;
                    c_CMD_SWRST: begin
                        // Software reset: everything except the free-running
                        // TE counter returns to its power-on value. The
                        // command strobe itself still reports 0x01.
                        w_soft_rst     = 1'b1;
                        w_state_nx     = IDLE;
                        w_x_nx         = 16'd0;
                        w_y_nx         = 16'd0;
                        w_sc_nx        = 16'd0;
                        w_ec_nx        = c_EC_RST;
                        w_sp_nx        = 16'd0;
                        w_ep_nx        = c_EP_RST;
                        w_disp_on_nx   = 1'b0;
                        w_sleep_out_nx = 1'b0;
                        w_te_en_nx     = 1'b0;
                        w_pix_x_nx     = 16'd0;
                        w_pix_y_nx     = 16'd0;
                        w_pix_data_nx  = 16'd0;
                    end
                    default: ;
                endcase
            end else begin
                case (r_state)
                    IDLE: begin
                        // Data with no command to own it.
                        w_err_nx = 1'b1;
                    end
                    CASET, PASET: begin
                        case (r_pidx)
                            2'd0: w_p0_nx = i_lcd_data;
                            2'd1: w_p1_nx = i_lcd_data;
                            2'd2: w_p2_nx = i_lcd_data;
                            default: begin
                                if (r_state == CASET) begin
                                    w_sc_nx = w_win_start;
                                    w_ec_nx = w_win_end;
                                end else begin
                                    w_sp_nx = w_win_start;
                                    w_ep_nx = w_win_end;
                                end
                                w_state_nx = IDLE;
                            end
                        endcase
                        w_pidx_nx = r_pidx + 2'd1;
                    end
                    RAMWR: begin
                        if (!r_phase) begin
                            w_byte0_nx = i_lcd_data;
                            w_phase_nx = 1'b1;
                        end else begin
                            w_phase_nx     = 1'b0;
                            w_pix_valid_nx = 1'b1;
                            w_pix_x_nx     = r_x;
                            w_pix_y_nx     = r_y;
                            w_pix_data_nx  = w_pix_word;
                            // Raster advance inside the window, wrapping to
                            // the window origin after the last pixel.
                            if (r_x == r_ec) begin
                                w_x_nx = r_sc;
                                w_y_nx = (r_y == r_ep) ? r_sp : r_y + 16'd1;
                            end else begin
                                w_x_nx = r_x + 16'd1;
                            end
                        end
                    end
                    default: ;  // OTHER: parameters silently ignored
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_wr_q      <= 1'b1;
            r_phase     <= 1'b0;
            r_pidx      <= 2'd0;
            r_p0        <= 8'd0;
            r_p1        <= 8'd0;
            r_p2        <= 8'd0;
            r_byte0     <= 8'd0;
            r_x         <= 16'd0;
            r_y         <= 16'd0;
            r_sc        <= 16'd0;
            r_ec        <= c_EC_RST;
            r_sp        <= 16'd0;
            r_ep        <= c_EP_RST;
            r_disp_on   <= 1'b0;
            r_sleep_out <= 1'b0;
            r_te_en     <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= 16'd0;
            r_pix_y     <= 16'd0;
            r_pix_data  <= 16'd0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_wr_q      <= i_lcd_wr;
            r_phase     <= w_phase_nx;
            r_pidx      <= w_pidx_nx;
            r_p0        <= w_p0_nx;
            r_p1        <= w_p1_nx;
            r_p2        <= w_p2_nx;
            r_byte0     <= w_byte0_nx;
            r_x         <= w_x_nx;
            r_y         <= w_y_nx;
            r_sc        <= w_sc_nx;
            r_ec        <= w_ec_nx;
            r_sp        <= w_sp_nx;
            r_ep        <= w_ep_nx;
            r_disp_on   <= w_disp_on_nx;
            r_sleep_out <= w_sleep_out_nx;
            r_te_en     <= w_te_en_nx;
            r_pix_valid <= w_pix_valid_nx;
            r_pix_x     <= w_pix_x_nx;
            r_pix_y     <= w_pix_y_nx;
            r_pix_data  <= w_pix_data_nx;
            r_cmd_valid <= w_cmd_valid_nx;
            r_cmd       <= w_cmd_nx;
            r_err       <= w_err_nx;
        end
    end

    // Tearing-effect generator: the frame counter never stops (not even for
    // software reset); only the output is gated by te_en.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_te_cnt <= '0;
            r_fmark  <= 1'b0;
        end else begin
            r_te_cnt <= (r_te_cnt == c_TE_LAST) ? '0 : r_te_cnt + 1'b1;
            r_fmark  <= w_soft_rst ? 1'b0 : (r_te_en && (r_te_cnt < c_TE_PULSE));
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_lcd_fmark = r_fmark;
    assign o_pix_valid = r_pix_valid;
    assign o_pix_x     = r_pix_x;
    assign o_pix_y     = r_pix_y;
    assign o_pix_data  = r_pix_data;
    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd       = r_cmd;
    assign o_disp_on   = r_disp_on;
    assign o_sleep_out = r_sleep_out;
    assign o_te_en     = r_te_en;
    assign o_err       = r_err;

endmodule
`default_nettype wire
